rf_scoreboard: RTL
==================

# rf_scoreboard

Per-register pending-write scoreboard for the 32×32 general-purpose register file: tracks how many issued instructions still owe a write to each register and stalls the issue stage on read-after-write and write-after-write hazards that forwarding cannot cover. It sits between the decode/issue stage (reads operands from the register file) and the writeback stage (drives the register file write port). Register 0 is never tracked.

## Interface
- `NREG`, 32, number of architectural registers; register index width is 5.
- `CNT_W`, 2, width of each pending counter; max pending writes per register = 2^CNT_W − 1 = 3.
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `issue_valid`  in  1  issue stage presents an instruction this cycle.
- `issue_rs`, `issue_rt`  in  5 each  source register indices.
- `issue_use_rs`, `issue_use_rt`  in  1 each  instruction actually reads that source.
- `issue_wr`  in  1  instruction will write a register.
- `issue_dst`  in  5  destination register index.
- `wb_valid`  in  1  writeback stage writes the register file this cycle.
- `wb_dst`  in  5  writeback destination index.
- `flush`  in  1  discard all in-flight instructions (exception/eret).
- `stall`  out  1  combinational; issue must hold its instruction.
- `issue_ack`  out  1  combinational; instruction accepted this cycle.
- `busy_mask`  out  32  bit i = counter i nonzero; bit 0 always 0.
- `outstanding`  out  7  registered total of all counters (max 31×3 = 93).
- `wb_err`  out  1  sticky: writeback to a register with zero pending count.

## Operation
- State: 31 counters `cnt[1..31]` of CNT_W bits, `outstanding`, `wb_err`.
- Source hazard on rs: `issue_use_rs && issue_rs != 0 && cnt[rs] != 0`, masked when `wb_valid && wb_dst == issue_rs && cnt[rs] == 1` (the register file write-through delivers the value this cycle). Same rule for rt.
- WAW/overflow hazard: `issue_wr && issue_dst != 0 && cnt[dst] == 3`.
- `stall = issue_valid && !flush && (rs hazard || rt hazard || overflow hazard)`.
- `issue_ack = issue_valid && !flush && !stall`.
- Increment: `issue_ack && issue_wr && issue_dst != 0` → `cnt[dst] + 1`.
- Decrement: `wb_valid && wb_dst != 0 && cnt[wb_dst] != 0` → `cnt[wb_dst] − 1`.
- Same register incremented and decremented in one cycle: counter unchanged.
- Writeback to index 0: ignored, no error.
- Writeback with `cnt[wb_dst] == 0` and `wb_dst != 0`: counter stays 0, `wb_err` set to 1 at next edge and held until reset.
- `outstanding` next = current + increment − decrement (each 0 or 1). No wrap; it cannot exceed 93 by construction.
- `flush`: at next edge all counters and `outstanding` go to 0, overriding same-cycle increment and decrement; `wb_err` unaffected. While `flush` is high, `issue_ack = 0` and `stall = 0`.

## Timing
- Reset (asynchronous, any time, including mid-stall): all counters = 0, `outstanding` = 0, `wb_err` = 0; thus `busy_mask` = 0, `stall` = 0, and `issue_ack = issue_valid` while reset is deasserted with no flush.
- `stall`/`issue_ack`: zero-latency combinational from inputs and current counter state.
- Counter, `busy_mask`, `outstanding` updates visible one cycle after the accepting/writing edge.
- A dependent instruction issued the cycle after its producer is accepted stalls until the producer's writeback cycle; it is accepted in that writeback cycle (bypass mask), not one later.
- No combinational path from `stall` back into any input; issue stage must hold all `issue_*` stable while stalled.

## Test plan
- Reset then idle: `busy_mask` = 0, `outstanding` = 0, `stall` = 0; `issue_valid=1, rs=5, use_rs=1` → `issue_ack=1` same cycle.
- RAW: issue `wr=1, dst=8`; next cycle issue `rs=8, use_rs=1` → `stall=1`, `busy_mask[8]=1`; assert `wb_valid, wb_dst=8` → `stall=0, issue_ack=1` that cycle; next cycle `busy_mask[8]=0`.
- Overflow: three accepted issues to dst=3 → `cnt[3]=3`, `outstanding=3`; fourth issue to dst=3 → `stall=1`; one writeback to 3 → next cycle it is accepted, `cnt` returns to 3.
- Simultaneous issue and writeback to dst=9 with `cnt=1` → `cnt` stays 1, `outstanding` unchanged; dst=0 issue/writeback → no change, no stall, no error.
- Spurious writeback: `wb_valid, wb_dst=12` with `cnt[12]=0` → `wb_err=1` next cycle, persists through `flush`, cleared only by `reset`.
- Flush with `outstanding=5` plus a same-cycle issue → `issue_ack=0`, next cycle all counters 0, `outstanding=0`; asynchronous `reset` pulse mid-stall → `stall` drops without a clock edge.

Source files
------------

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for the 32x32 register file: one saturating-free
// counter per architectural register, RAW/WAW issue stall, writeback bookkeeping.

module rf_sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Top guarantees inc never hits a full counter and dec never hits an empty one.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i)             cnt_d = '0;
    else if (inc_i && !dec_i) cnt_d = cnt_q + CNT_W'(1);
    else if (dec_i && !inc_i) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

module rf_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    issue_valid_i,
  input  logic [$clog2(NREG)-1:0] issue_rs_i,
  input  logic [$clog2(NREG)-1:0] issue_rt_i,
  input  logic                    issue_use_rs_i,
  input  logic                    issue_use_rt_i,
  input  logic                    issue_wr_i,
  input  logic [$clog2(NREG)-1:0] issue_dst_i,
  input  logic                    wb_valid_i,
  input  logic [$clog2(NREG)-1:0] wb_dst_i,
  input  logic                    flush_i,
  output logic                    stall_o,
  output logic                    issue_ack_o,
  output logic [NREG-1:0]         busy_mask_o,
  output logic [6:0]              outstanding_o,
  output logic                    wb_err_o
);
  localparam int IDX_W = $clog2(NREG);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0]            inc_vec, dec_vec;
  logic [CNT_W-1:0]           cnt_rs, cnt_rt, cnt_dst, cnt_wb;
  logic                       rs_haz, rt_haz, ovf_haz;
  logic                       inc, dec, spurious_wb;
  logic [6:0]                 outstanding_q, outstanding_d;
  logic                       wb_err_q, wb_err_d;

  assign cnt[0]      = '0;
  assign inc_vec[0]  = 1'b0;
  assign dec_vec[0]  = 1'b0;

  generate
    for (genvar r = 1; r < NREG; r++) begin : g_reg
      assign inc_vec[r] = inc && (issue_dst_i == IDX_W'(r));
      assign dec_vec[r] = dec && (wb_dst_i == IDX_W'(r));
      rf_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (flush_i),
        .inc_i   (inc_vec[r]),
        .dec_i   (dec_vec[r]),
        .cnt_o   (cnt[r])
      );
    end
  endgenerate

  assign cnt_rs  = cnt[issue_rs_i];
  assign cnt_rt  = cnt[issue_rt_i];
  assign cnt_dst = cnt[issue_dst_i];
  assign cnt_wb  = cnt[wb_dst_i];

  // Last pending write landing this cycle is bypassed by register-file write-through.
  assign rs_haz  = issue_use_rs_i && (issue_rs_i != '0) && (cnt_rs != '0) &&
                   !(wb_valid_i && (wb_dst_i == issue_rs_i) && (cnt_rs == CNT_ONE));
  assign rt_haz  = issue_use_rt_i && (issue_rt_i != '0) && (cnt_rt != '0) &&
                   !(wb_valid_i && (wb_dst_i == issue_rt_i) && (cnt_rt == CNT_ONE));
  assign ovf_haz = issue_wr_i && (issue_dst_i != '0) && (cnt_dst == CNT_MAX);

  assign stall_o     = issue_valid_i && !flush_i && (rs_haz || rt_haz || ovf_haz);
  assign issue_ack_o = issue_valid_i && !flush_i && !stall_o;

  assign inc         = issue_ack_o && issue_wr_i && (issue_dst_i != '0);
  assign dec         = wb_valid_i && (wb_dst_i != '0) && (cnt_wb != '0);
  assign spurious_wb = wb_valid_i && (wb_dst_i != '0) && (cnt_wb == '0);

  always_comb begin
    outstanding_d = outstanding_q + 7'(inc) - 7'(dec);
    if (flush_i) outstanding_d = '0;
    wb_err_d = wb_err_q || spurious_wb;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      outstanding_q <= '0;
      wb_err_q      <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      wb_err_q      <= wb_err_d;
    end
  end

  generate
    for (genvar i = 0; i < NREG; i++) begin : g_busy
      assign busy_mask_o[i] = |cnt[i];
    end
  endgenerate

  assign outstanding_o = outstanding_q;
  assign wb_err_o      = wb_err_q;
endmodule
